// File: rtl/sig_pattern_pkg.sv
// Shared types and constants for the pattern playback generator.
package sig_pattern_pkg;

  typedef enum logic [0:0] {
    IDLE,
    PLAY
  } state_e;

  localparam logic MODE_LOOP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/sig_rate_div.sv
// Sample-rate divider: counts 0..rate_i and emits a tick on the terminal count.
// clr_i makes the current cycle count as position 0, so a start cycle can tick immediately
// when rate_i is 0.
module sig_rate_div #(
  parameter int unsigned RATE_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [RATE_W-1:0] rate_i,
  output logic              tick_o
);

  logic [RATE_W-1:0] cnt_q, cnt_d, cnt_eff;

  // Terminal-count detection and next count; a disabled divider parks at zero.
  always_comb begin
    cnt_eff = clr_i ? '0 : cnt_q;
    tick_o  = en_i && (cnt_eff == rate_i);
    cnt_d   = (!en_i || tick_o) ? '0 : cnt_eff + 1'b1;
  end

  // Counter state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sig_pattern_player.sv
// Pattern playback generator: holds DEPTH signed words and plays them one per sample tick,
// in loop or one-shot mode, with programmable length and rate.
module sig_pattern_player
  import sig_pattern_pkg::*;
#(
  parameter int unsigned WORD_W = 65,
  parameter int unsigned DEPTH  = 30,
  parameter int unsigned RATE_W = 16,
  parameter int unsigned LEN_W  = $clog2(DEPTH + 1)
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic [WORD_W*DEPTH-1:0]  bit_in,
  input  logic                     load,
  input  logic [LEN_W-1:0]         len,
  input  logic                     mode,
  input  logic [RATE_W-1:0]        rate,
  input  logic                     start,
  input  logic                     stop,
  output logic signed [WORD_W-1:0] sig_out,
  output logic                     sig_valid,
  output logic                     busy,
  output logic                     wrap,
  output logic                     done
);

  state_e                   state_q;
  logic [WORD_W*DEPTH-1:0]  store_q;
  logic [LEN_W-1:0]         idx_q, len_q;
  logic [RATE_W-1:0]        rate_q;
  logic                     mode_q;
  // Set by the final one-shot sample; the following cycle returns to IDLE with done.
  logic                     fin_q;

  logic                     start_ok, run, tick, last;
  logic [LEN_W-1:0]         len_in_eff, idx_cur, len_cur;
  logic [RATE_W-1:0]        rate_sel;
  logic                     mode_cur;
  logic [WORD_W-1:0]        cur_word;

  // Qualify control and select live vs. latched settings; the start cycle uses the inputs.
  always_comb begin
    start_ok   = (state_q == IDLE) && start && !stop;
    run        = (state_q == PLAY) && !stop && !fin_q;
    if (len == '0) begin
      len_in_eff = LEN_W'(1);
    end else if (len > LEN_W'(DEPTH)) begin
      len_in_eff = LEN_W'(DEPTH);
    end else begin
      len_in_eff = len;
    end
    rate_sel   = start_ok ? rate : rate_q;
    idx_cur    = start_ok ? '0 : idx_q;
    len_cur    = start_ok ? len_in_eff : len_q;
    mode_cur   = start_ok ? mode : mode_q;
    last       = (idx_cur == len_cur - LEN_W'(1));
    cur_word   = store_q[32'(idx_cur) * WORD_W +: WORD_W];
  end

  sig_rate_div #(
    .RATE_W (RATE_W)
  ) u_rate_div (
    .clk_i  (Clk),
    .rst_ni (Rst_n),
    .clr_i  (start_ok),
    .en_i   (start_ok || run),
    .rate_i (rate_sel),
    .tick_o (tick)
  );

  // FSM, word store, index and registered outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      store_q   <= '0;
      idx_q     <= '0;
      len_q     <= '0;
      rate_q    <= '0;
      mode_q    <= MODE_LOOP;
      fin_q     <= 1'b0;
      sig_out   <= '0;
      sig_valid <= 1'b0;
      busy      <= 1'b0;
      wrap      <= 1'b0;
      done      <= 1'b0;
    end else begin
      sig_valid <= 1'b0;
      wrap      <= 1'b0;
      done      <= 1'b0;

      if ((state_q == IDLE) && load) begin
        store_q <= bit_in;
      end

      case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_q <= PLAY;
            busy    <= 1'b1;
            len_q   <= len_in_eff;
            rate_q  <= rate;
            mode_q  <= mode;
            idx_q   <= '0;
            fin_q   <= 1'b0;
          end
        end
        PLAY: begin
          if (stop || fin_q) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            idx_q   <= '0;
            fin_q   <= 1'b0;
            done    <= !stop;
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase

      // Ticks only occur on a start cycle or while actively playing.
      if (tick) begin
        sig_out   <= cur_word;
        sig_valid <= 1'b1;
        if (last) begin
          idx_q <= '0;
          if (mode_cur == MODE_ONESHOT) begin
            fin_q <= 1'b1;
          end else begin
            wrap <= 1'b1;
          end
        end else begin
          idx_q <= idx_cur + LEN_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/sig_pattern_player.md
# sig_pattern_player

Parametrised pattern playback generator: captures a flat bit vector as DEPTH signed words of WORD_W bits and plays them out one word per sample tick. Supports programmable active length, rate division, loop and one-shot modes, and start/stop control. Sits at the modulation-input end of the DDS chain, feeding the bitstream/modulating signal into the phase/amplitude path.

## Interface
- WORD_W, 65, bits per output word (signed)
- DEPTH, 30, number of words held
- RATE_W, 16, width of the rate-divider setting
- LEN_W, $clog2(DEPTH+1), width of the length input (derived)
- Clk  in  1  single clock, all logic on rising edge
- Rst_n  in  1  asynchronous active-low reset
- bit_in  in  WORD_W*DEPTH  pattern source; word k = bit_in[k*WORD_W +: WORD_W]
- load  in  1  capture bit_in into the word store
- len  in  LEN_W  active word count, latched at start
- mode  in  1  0 = loop, 1 = one-shot
- rate  in  RATE_W  sample period minus one, latched at start
- start  in  1  begin playback from word 0
- stop  in  1  abort playback
- sig_out  out  WORD_W  current sample (signed, registered)
- sig_valid  out  1  one-cycle strobe per new sample
- busy  out  1  high while in PLAY
- wrap  out  1  one-cycle pulse when loop mode returns to word 0
- done  out  1  one-cycle pulse after the last one-shot sample

## Operation
- Word store: DEPTH x WORD_W registers; load copies all words in one cycle, no overlap or gap between slices.
- load honoured only in IDLE; ignored in PLAY (store contents stable during playback).
- FSM states: IDLE, PLAY.
  - IDLE -> PLAY on start (latch len, mode, rate; idx=0; div=0).
  - PLAY -> IDLE on stop, or after last word in one-shot.
- Length rule: len=0 treated as 1; len>DEPTH clamped to DEPTH.
- Sample tick: divider counts 0..rate; tick when div==rate, then div=0. rate=0 gives one sample per cycle.
- On each tick in PLAY: sig_out<=store[idx], sig_valid<=1; idx increments; at idx==len_eff-1:
  - loop: idx->0, wrap pulses with that sample.
  - one-shot: go IDLE, done pulses one cycle after the last sig_valid.
- sig_out holds its last value between ticks and after stop/done.
- stop and start same cycle: stop wins; start in PLAY ignored.

## Timing
- Reset values: sig_out=0, sig_valid=0, busy=0, wrap=0, done=0, FSM=IDLE, idx=0, div=0, store cleared to 0.
- Reset asserted mid-playback: immediate return to reset values, no done/wrap pulse.
- start at cycle N: busy=1 at N+1; first sig_valid with word 0 at N+1+rate.
- Subsequent samples every rate+1 cycles.
- load at cycle N: new words visible to a start at N+1 or later.
- stop at cycle N: busy=0 at N+1, no sig_valid from N+1.
- One-shot, len_eff=L, rate=R: last sig_valid at N+1+R+(L-1)(R+1); done at next cycle, busy falls with done.

## Structure
- Package sig_pattern_pkg: state enum (IDLE, PLAY), mode constants MODE_LOOP/MODE_ONESHOT.
- Sub-module sig_rate_div: RATE_W counter with clear, enable, and tick output; instantiated once.
- Top holds store, FSM, index and output registers; target 150-250 lines.

## Test plan
- WORD_W=8, DEPTH=4, load words {1,-2,3,-4}, len=4, loop, rate=0, start -> sig_out 1,-2,3,-4,1,... every cycle, wrap with each -4.
- Same store, len=3, one-shot, rate=2 -> sig_valid every 3 cycles with 1,-2,3; done one cycle after 3; busy low after.
- len=0 one-shot -> single sample 1 then done; len=7 -> behaves as len=4.
- stop asserted after second sample with start in same cycle -> busy drops next cycle, sig_out holds -2, no further sig_valid.
- load with new values during PLAY -> output sequence unchanged; after stop and start, new values played.
- Rst_n pulsed low mid-loop asynchronously -> all outputs 0 immediately, store cleared, no done/wrap.
